// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, iteration count.
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int ITER = 32;

endpackage

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers, plus MTHI/MTLO writes.
// Latency: result in HI/LO 32 edges after the accepting edge, done pulses the cycle after.
// Backpressure: none; busy tells the core to stall, start while busy is dropped.
module mdu
    import mdu_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(ITER);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;
    logic             sa_q;
    logic             div0_q;
    logic [WIDTH-1:0] opb;
    logic [W2-1:0]    work;

    logic [W2-1:0]    shifted;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic [WIDTH:0]   add_y;
    logic             q_bit;
    logic [W2-1:0]    work_nxt;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    logic             accept;
    logic             signed_op;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    assign accept    = start && (state != RUN);
    assign signed_op = ~op[0];
    assign a_abs     = (signed_op && A[WIDTH-1]) ? -A : A;
    assign b_abs     = (signed_op && B[WIDTH-1]) ? -B : B;

    // One shared adder: add for shift-add multiply, trial subtract for restoring divide.
    always_comb begin
        shifted = {work[W2-2:0], 1'b0};
        add_a   = is_div ? {1'b0, shifted[W2-1:WIDTH]} : {1'b0, work[W2-1:WIDTH]};
        add_b   = {1'b0, opb};
        add_y   = is_div ? (add_a - add_b) : (add_a + add_b);
        // The bit shifted out of the remainder is the 33rd bit of the trial value.
        q_bit   = work[W2-1] | ~add_y[WIDTH];

        if (is_div) begin
            work_nxt = q_bit ? {add_y[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1} : shifted;
        end else begin
            work_nxt = work[0] ? {add_y, work[WIDTH-1:1]}
                               : {1'b0, work[W2-1:WIDTH], work[WIDTH-1:1]};
        end
    end

    // Divide-by-zero leaves the dividend magnitude in rem, so the remainder fix restores raw A.
    always_comb begin
        prod_fix = neg_q ? -work_nxt : work_nxt;
        quo_fix  = neg_q ? -work_nxt[WIDTH-1:0] : work_nxt[WIDTH-1:0];
        rem_fix  = sa_q ? -work_nxt[W2-1:WIDTH] : work_nxt[W2-1:WIDTH];
        res_hi   = is_div ? rem_fix : prod_fix[W2-1:WIDTH];
        res_lo   = is_div ? (div0_q ? DIV0_LO : quo_fix) : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            sa_q   <= 1'b0;
            div0_q <= 1'b0;
            opb    <= '0;
            work   <= '0;
            HI     <= '0;
            LO     <= '0;
        end else if (state == RUN) begin
            work <= work_nxt;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(ITER - 1)) begin
                HI    <= res_hi;
                LO    <= res_lo;
                state <= DONE;
            end
        end else begin
            if (hi_we) HI <= wdata;
            if (lo_we) LO <= wdata;
            if (accept) begin
                is_div <= op[1];
                neg_q  <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                sa_q   <= signed_op && A[WIDTH-1];
                div0_q <= op[1] && (B == '0);
                cnt    <= '0;
                state  <= RUN;
                if (op[1]) begin
                    opb  <= b_abs;
                    work <= {{WIDTH{1'b0}}, a_abs};
                end else begin
                    opb  <= a_abs;
                    work <= {{WIDTH{1'b0}}, b_abs};
                end
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Randomized and directed bench for mdu against an arithmetic reference model.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int          checks;
    int          errors;
    logic [31:0] ehi;
    logic [31:0] elo;

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference: returns {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            MDU_MULT:  return 64'(sa * sb);
            MDU_MULTU: return ua * ub;
            MDU_DIV: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // now=1: already at the negedge of the DONE cycle, launch back-to-back.
    // poke=1: fire a stray start and MT writes at iteration 10, which must be ignored.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit now, input bit poke);
        logic [63:0] m;
        int n;
        if (!now) @(negedge clk);
        start = 1; op = o; A = a; B = b;
        @(negedge clk);
        start = 0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (poke && n == 10) begin
                start = 1; op = MDU_MULT; A = $urandom; B = $urandom;
                hi_we = 1; lo_we = 1; wdata = 32'hDEADBEEF;
            end
            @(negedge clk);
            start = 0; hi_we = 0; lo_we = 0;
        end
        m   = model(o, a, b);
        ehi = m[63:32];
        elo = m[31:0];
        chk("busy_cycles", 64'(n), 64'd32);
        chk("done_pulse", {63'b0, done}, 64'd1);
        chk("hi", {32'b0, HI}, {32'b0, ehi});
        chk("lo", {32'b0, LO}, {32'b0, elo});
    endtask

    task automatic finish_op();
        @(negedge clk);
        chk("done_clear", {63'b0, done}, 64'd0);
        chk("idle", {63'b0, busy}, 64'd0);
        chk("hold", {HI, LO}, {ehi, elo});
    endtask

    task automatic mt_write(input bit wh, input bit wl, input logic [31:0] d);
        @(negedge clk);
        hi_we = wh; lo_we = wl; wdata = d;
        @(negedge clk);
        hi_we = 0; lo_we = 0;
        if (wh) ehi = d;
        if (wl) elo = d;
        chk("mt_hi", {32'b0, HI}, {32'b0, ehi});
        chk("mt_lo", {32'b0, LO}, {32'b0, elo});
    endtask

    initial begin
        int n;
        bit chain;
        logic [1:0] o;
        logic [31:0] a, b;
        clk = 0; reset = 0; start = 0; op = 0; A = 0; B = 0;
        hi_we = 0; lo_we = 0; wdata = 0;
        ehi = 0; elo = 0;
        checks = 0; errors = 0;

        repeat (2) @(negedge clk);
        chk("rst_hilo", {HI, LO}, 64'd0);
        chk("rst_flags", {62'b0, busy, done}, 64'd0);
        reset = 1;
        @(negedge clk);

        do_op(MDU_MULT, 32'hFFFFFFFD, 32'd7, 0, 0);
        chk("mult_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFEB);
        finish_op();
        do_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        chk("multu_const", {HI, LO}, 64'hFFFFFFFE_00000001);
        finish_op();
        do_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, 0, 0);
        chk("div_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        finish_op();
        do_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        chk("div_ovf", {HI, LO}, 64'h00000000_80000000);
        finish_op();
        do_op(MDU_DIVU, 32'd100, 32'd0, 0, 0);
        chk("div0", {HI, LO}, 64'h00000064_FFFFFFFF);
        finish_op();

        do_op(MDU_DIVU, 32'd1000, 32'd3, 0, 1);
        chk("divu_poke", {HI, LO}, {32'd1, 32'd333});
        do_op(MDU_MULT, 32'd12345, 32'hFFFFFFF7, 1, 0);
        finish_op();

        mt_write(1, 0, 32'h12345678);

        // Start and MTLO on the same edge: MT lands first, the result overwrites it.
        @(negedge clk);
        start = 1; op = MDU_MULTU; A = 32'd3; B = 32'd5; lo_we = 1; wdata = 32'hAAAA5555;
        @(negedge clk);
        start = 0; lo_we = 0;
        chk("mt_with_start", {32'b0, LO}, 64'hAAAA5555);
        n = 0;
        while (!done && n < 100) begin
            n++;
            @(negedge clk);
        end
        ehi = 0; elo = 32'd15;
        chk("mt_then_result", {HI, LO}, {ehi, elo});
        finish_op();

        mt_write(1, 0, 32'h12345678);
        @(negedge clk);
        start = 1; op = MDU_MULT; A = 32'd2; B = 32'd3;
        @(negedge clk);
        start = 0;
        repeat (10) @(negedge clk);
        reset = 0;
        #1;
        chk("rst_mid_hilo", {HI, LO}, 64'd0);
        chk("rst_mid_flags", {62'b0, busy, done}, 64'd0);
        @(negedge clk);
        reset = 1;
        ehi = 0; elo = 0;
        @(negedge clk);
        chk("post_rst_idle", {62'b0, busy, done}, 64'd0);
        do_op(MDU_MULT, 32'd2, 32'd3, 0, 0);
        finish_op();

        chain = 0;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            if (!chain && $urandom_range(0, 3) == 0)
                mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            do_op(o, a, b, chain, $urandom_range(0, 4) == 0);
            chain = ($urandom_range(0, 2) == 0);
            if (!chain) finish_op();
        end
        if (chain) finish_op();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
